// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked WIDTH-bit ALU with registered result and flags.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR; iterative MUL (shift-add) and
// DIV (restoring) are built only when the macro ULA_MULDIV_EN is defined.
// Without ULA_MULDIV_EN, MUL/DIV codes behave as undefined ops and the
// EXEC state is never entered.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] val_a,
    input  logic [WIDTH-1:0] val_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             negative_flag,
    output logic             div_zero_flag
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
`ifdef ULA_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam int CNT_W = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic             accept;
    logic             start_iter;

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             negative_reg;

    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_negative;
    logic [WIDTH:0]   sc_wide;
    logic [WIDTH:0]   shr_wide;
    logic [SH_W-1:0]  sh_amt;

    assign accept = (state_reg == S_IDLE) && start;
    assign sh_amt = val_b[SH_W-1:0];

`ifdef ULA_MULDIV_EN
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             op_div_reg;
    logic             div_zero_reg;
    logic             last_step;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign start_iter    = (op == OP_MUL) || (op == OP_DIV);
    assign last_step     = (state_reg == S_EXEC) && (cnt_reg == CNT_W'(1));
    assign div_zero_flag = div_zero_reg;
`else
    assign start_iter    = 1'b0;
    assign div_zero_flag = 1'b0;
`endif

    assign result        = result_reg;
    assign result_hi     = result_hi_reg;
    assign zero_flag     = zero_reg;
    assign carry_flag    = carry_reg;
    assign negative_flag = negative_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: starts are only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = start_iter ? S_EXEC : S_FINISH;
                end
            end
            S_EXEC: begin
`ifdef ULA_MULDIV_EN
                if (last_step) begin
                    state_next = S_FINISH;
                end
`else
                state_next = S_IDLE;
`endif
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = (state_reg != S_IDLE);
        done = (state_reg == S_FINISH);
    end

    // Single-cycle operation results straight from the request inputs
    always_comb begin
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_negative = 1'b0;
        sc_wide     = '0;
        shr_wide    = '0;
        case (op)
            OP_ADD: begin
                sc_wide   = {1'b0, val_a} + {1'b0, val_b};
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_SUB: begin
                sc_wide     = {1'b0, val_a} - {1'b0, val_b};
                sc_result   = sc_wide[WIDTH-1:0];
                sc_carry    = sc_wide[WIDTH];
                sc_negative = (val_b > val_a);
            end
            OP_AND: sc_result = val_a & val_b;
            OP_OR:  sc_result = val_a | val_b;
            OP_XOR: sc_result = val_a ^ val_b;
            OP_SHL: begin
                // The extra top bit catches the last bit shifted out
                sc_wide   = {1'b0, val_a} << sh_amt;
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_SHR: begin
                // The extra bottom bit catches the last bit shifted out
                shr_wide  = {val_a, 1'b0} >> sh_amt;
                sc_result = shr_wide[WIDTH:1];
                sc_carry  = shr_wide[0];
            end
            default: ;
        endcase
    end

`ifdef ULA_MULDIV_EN
    // One shift-add (MUL) or restoring-subtract (DIV) step from the accumulators
    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[WIDTH-1:0] - opb_reg;
        if (op_div_reg) begin
            step_hi = div_fits ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_reg[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    // Iteration accumulators and counter; a divisor of zero naturally yields
    // an all-ones quotient with the dividend left as remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            op_div_reg <= 1'b0;
        end else if (accept && start_iter) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= val_a;
            opb_reg    <= val_b;
            cnt_reg    <= CNT_W'(WIDTH);
            op_div_reg <= (op == OP_DIV);
        end else if (state_reg == S_EXEC) begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg - CNT_W'(1);
        end
    end
`endif

    // Result and flag registers: written only on the edge that enters FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b1;
            carry_reg     <= 1'b0;
            negative_reg  <= 1'b0;
`ifdef ULA_MULDIV_EN
            div_zero_reg  <= 1'b0;
`endif
        end else if (accept && !start_iter) begin
            result_reg    <= sc_result;
            result_hi_reg <= '0;
            zero_reg      <= (sc_result == '0);
            carry_reg     <= sc_carry;
            negative_reg  <= sc_negative;
`ifdef ULA_MULDIV_EN
            div_zero_reg  <= 1'b0;
        end else if (last_step) begin
            result_reg    <= step_lo;
            result_hi_reg <= step_hi;
            zero_reg      <= (step_lo == '0);
            carry_reg     <= op_div_reg ? 1'b0 : (step_hi != '0);
            negative_reg  <= 1'b0;
            div_zero_reg  <= op_div_reg && (opb_reg == '0);
`endif
        end
    end

endmodule
